// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers,
// with bounded bursts. Define UART_ARB_TAG_EN to prefix each new grant with a tag byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 o_tx_dv,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_busy,
  output logic [1:0]           dbg_state
);

  localparam int BC_W = $clog2(MAX_BURST) + 1;

  // Handshake: requester i holds req_valid[i] and its byte until req_ready[i]
  // pulses for one cycle (the SEND cycle); dropping valid earlier withdraws the byte.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
`ifdef UART_ARB_TAG_EN
    ,TAG = 2'd3
`endif
  } state_t;

  state_t           state, state_n;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_n;
  logic [ID_W-1:0]  grant_n;
  logic [BC_W-1:0]  burst_cnt, burst_n;
  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  logic             dv_n;
  logic [NUM_REQ-1:0] ready_n;
  logic [7:0]       byte_n;
  logic             busy_n;
`ifdef UART_ARB_TAG_EN
  logic             tag_phase, tag_phase_n;
`endif

  assign dbg_state = state;

  // First valid requester starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_valid && req_valid[idx]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = o_grant_id;
    rr_ptr_n = rr_ptr;
    burst_n  = burst_cnt;
`ifdef UART_ARB_TAG_EN
    tag_phase_n = tag_phase;
`endif
    case (state)
      IDLE: begin
        if (!i_tx_active && pick_valid) begin
          grant_n = pick_id;
          burst_n = '0;
`ifdef UART_ARB_TAG_EN
          state_n = TAG;
`else
          state_n = SEND;
`endif
        end
      end
      SEND: begin
        state_n = WAIT;
`ifdef UART_ARB_TAG_EN
        tag_phase_n = 1'b0;
`endif
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        state_n     = WAIT;
        tag_phase_n = 1'b1;
      end
`endif
      WAIT: begin
        if (i_tx_done) begin
`ifdef UART_ARB_TAG_EN
          if (tag_phase && req_valid[o_grant_id]) begin
            state_n = SEND;
          end else if (!tag_phase && req_valid[o_grant_id] &&
                       burst_cnt < BC_W'(MAX_BURST - 1)) begin
            burst_n = burst_cnt + BC_W'(1);
            state_n = SEND;
          end else begin
            rr_ptr_n = (int'(o_grant_id) == NUM_REQ - 1) ? '0 : o_grant_id + ID_W'(1);
            state_n  = IDLE;
          end
`else
          if (req_valid[o_grant_id] && burst_cnt < BC_W'(MAX_BURST - 1)) begin
            burst_n = burst_cnt + BC_W'(1);
            state_n = SEND;
          end else begin
            rr_ptr_n = (int'(o_grant_id) == NUM_REQ - 1) ? '0 : o_grant_id + ID_W'(1);
            state_n  = IDLE;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    dv_n    = 1'b0;
    ready_n = '0;
    byte_n  = o_tx_byte;
    busy_n  = (state_n != IDLE);
    if (state_n == SEND) begin
      dv_n    = 1'b1;
      ready_n = NUM_REQ'(1) << grant_n;
      byte_n  = req_byte[8*int'(grant_n) +: 8];
    end
`ifdef UART_ARB_TAG_EN
    if (state_n == TAG) begin
      dv_n   = 1'b1;
      byte_n = {4'hA, 1'b0, 3'(grant_n)};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      burst_cnt  <= '0;
      o_grant_id <= '0;
      o_tx_dv    <= 1'b0;
      o_tx_byte  <= 8'h00;
      req_ready  <= '0;
      o_busy     <= 1'b0;
`ifdef UART_ARB_TAG_EN
      tag_phase  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      burst_cnt  <= burst_n;
      o_grant_id <= grant_n;
      o_tx_dv    <= dv_n;
      o_tx_byte  <= byte_n;
      req_ready  <= ready_n;
      o_busy     <= busy_n;
`ifdef UART_ARB_TAG_EN
      tag_phase  <= tag_phase_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (default build): behavioural UART responder,
// byte-producing requesters and a scoreboard of expected {grant, byte} frames.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 2;
  localparam int ID_W      = 3;
  localparam int FRAME     = 20;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 o_tx_dv;
  logic [7:0]           o_tx_byte;
  logic                 tx_active;
  logic                 tx_done;
  logic                 stray_done;
  logic [ID_W-1:0]      o_grant_id;
  logic                 o_busy;
  logic [1:0]           dbg_state;

  logic [7:0]  req_bytes [NUM_REQ];
  int          rem       [NUM_REQ];
  int          ready_cnt [NUM_REQ];
  logic        byte_inc;

  logic [10:0] exp_q [$];
  int          gap_q [$];
  int          cyc, last_done, frame_cnt, dv_overlap;
  logic [7:0]  cur_byte;
  logic [2:0]  cur_gid;
  logic        frame_rst;
  int          n_cmp, n_err;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_byte(req_byte),
    .req_ready(req_ready), .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
    .i_tx_active(tx_active), .i_tx_done(tx_done | stray_done),
    .o_grant_id(o_grant_id), .o_busy(o_busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_byte[8*i +: 8] = req_bytes[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: UART responder, scoreboard and requester reaction to req_ready.
  task automatic tick();
    logic [10:0] e;
    @(negedge clk);
    cyc++;
    tx_done = 1'b0;
    if (o_tx_dv) begin
      if (tx_active) dv_overlap++;
      tx_active = 1'b1;
      frame_cnt = FRAME;
      cur_byte  = o_tx_byte;
      cur_gid   = o_grant_id;
      frame_rst = 1'b0;
      gap_q.push_back(cyc - last_done);
    end else if (tx_active) begin
      frame_cnt--;
      if (frame_cnt == 0) begin
        tx_active = 1'b0;
        tx_done   = 1'b1;
        last_done = cyc;
        if (!frame_rst) check("byte_hold", o_tx_byte, cur_byte);
        if (exp_q.size() == 0) check("sb_empty", 0, 1);
        else begin
          e = exp_q.pop_front();
          check("frame", {cur_gid, cur_byte}, e);
        end
      end
    end
    if (req_ready != '0) begin
      check("ready_onehot", $onehot(req_ready), 1);
      check("ready_with_dv", o_tx_dv, 1);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        ready_cnt[i]++;
        if (rem[i] > 0) rem[i]--;
        if (byte_inc) req_bytes[i] = req_bytes[i] + 8'd1;
        if (rem[i] == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((o_busy || tx_active || exp_q.size() != 0) && n < budget);
    if (o_busy || tx_active || exp_q.size() != 0) check("timeout_idle", 0, 1);
  endtask

  task automatic push_exp(input int gid, input logic [7:0] b);
    exp_q.push_back({3'(gid), b});
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; last_done = 0; frame_cnt = 0; dv_overlap = 0;
    rst = 1'b1; req_valid = '0; tx_active = 1'b0; tx_done = 1'b0; stray_done = 1'b0;
    byte_inc = 1'b0; frame_rst = 1'b0; cur_byte = '0; cur_gid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = '0; rem[i] = 0; ready_cnt[i] = 0;
    end

    // Reset state
    repeat (3) tick();
    check("rst_dv", o_tx_dv, 0);
    check("rst_byte", o_tx_byte, 8'h00);
    check("rst_gid", o_grant_id, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single requester, single byte; latency of one cycle.
    req_bytes[0] = 8'h55; rem[0] = 1; req_valid[0] = 1'b1;
    push_exp(0, 8'h55);
    tick();
    check("t1_dv", o_tx_dv, 1);
    check("t1_ready", req_ready, 4'b0001);
    check("t1_busy", o_busy, 1);
    tick();
    check("t1_dv_pulse", o_tx_dv, 0);
    check("t1_state_wait", dbg_state, 2);
    wait_idle(500);
    check("t1_gid", o_grant_id, 0);

    // All valid, bursts of two; rr_ptr is 1 after the previous grant of req0.
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = 8'h10 + 8'(i); rem[i] = 4; ready_cnt[i] = 0;
    end
    req_valid = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      push_exp(1, 8'h11); push_exp(1, 8'h11);
      push_exp(2, 8'h12); push_exp(2, 8'h12);
      push_exp(3, 8'h13); push_exp(3, 8'h13);
      push_exp(0, 8'h10); push_exp(0, 8'h10);
    end
    wait_idle(3000);
    for (int i = 0; i < NUM_REQ; i++) check("t2_ready_cnt", ready_cnt[i], 4);

    // Reset mid-frame: arbiter must wait for the in-flight frame to finish.
    dv_overlap = 0;
    req_bytes[0] = 8'h3C; rem[0] = 1; req_valid[0] = 1'b1;
    push_exp(0, 8'h3C);
    for (int n = 0; n < 10 && !tx_active; n++) tick();
    check("t3_started", tx_active, 1);
    repeat (5) tick();
    rst = 1'b1; frame_rst = 1'b1;
    #1;
    check("t3_rst_byte", o_tx_byte, 8'h00);
    check("t3_rst_busy", o_busy, 0);
    check("t3_rst_dv", o_tx_dv, 0);
    tick(); tick();
    rst = 1'b0;
    gap_q.delete();
    req_bytes[1] = 8'h77; rem[1] = 1; req_valid[1] = 1'b1;
    push_exp(1, 8'h77);
    wait_idle(500);
    check("t3_no_dv_while_active", dv_overlap, 0);
    check("t3_gap_cnt", gap_q.size(), 1);
    if (gap_q.size() > 0) check("t3_gap", gap_q[0], 1);

    // A done pulse outside WAIT is ignored.
    tick();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    check("stray_busy", o_busy, 0);
    check("stray_dv", o_tx_dv, 0);

    // req2 alone with three bytes: burst of two, one idle cycle, re-grant to req2.
    // req3 raises and withdraws valid mid-frame and must send nothing.
    byte_inc = 1'b1;
    req_bytes[2] = 8'h20; rem[2] = 3; req_valid[2] = 1'b1;
    push_exp(2, 8'h20); push_exp(2, 8'h21); push_exp(2, 8'h22);
    gap_q.delete();
    tick();
    check("t4_dv", o_tx_dv, 1);
    check("t4_ready", req_ready, 4'b0100);
    check("t4_gid", o_grant_id, 2);
    repeat (3) tick();
    req_bytes[3] = 8'h99; rem[3] = 1; req_valid[3] = 1'b1;
    repeat (3) tick();
    req_valid[3] = 1'b0; rem[3] = 0;
    wait_idle(1000);
    byte_inc = 1'b0;
    check("t4_gap_cnt", gap_q.size(), 3);
    if (gap_q.size() == 3) begin
      check("t4_gap_burst", gap_q[1], 1);
      check("t4_gap_rotate", gap_q[2], 2);
    end

    // All valid with rr_ptr=3: grant 3 first, then 0, 1, 2.
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = 8'h40 + 8'(i); rem[i] = 1;
    end
    req_valid = 4'b1111;
    push_exp(3, 8'h43); push_exp(0, 8'h40); push_exp(1, 8'h41); push_exp(2, 8'h42);
    tick();
    check("t5_gid", o_grant_id, 3);
    check("t5_ready", req_ready, 4'b1000);
    wait_idle(1000);

    check("sb_drained", exp_q.size(), 0);
    check("dv_overlap", dv_overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
